// File: rtl/masked_pkg.sv
// Shared constants, LFSR step helper and share-bundle payload type for the
// masked XOR share feeder.
package masked_pkg;

   localparam int unsigned LFSR_W     = 32;
   localparam int unsigned MASK_BITS  = 5;
   localparam int unsigned LFSR_STEPS = 5;
   localparam int unsigned DEF_WARMUP = 8;

   localparam logic [LFSR_W-1:0] DEF_POLY = 32'h8020_0003;
   localparam logic [LFSR_W-1:0] DEF_SEED = 32'h1ACE_B00C;

   // One share bundle: operand shares plus the gadget's fresh randomness.
   typedef struct packed {
      logic A0;
      logic A1;
      logic B0;
      logic B1;
      logic r0;
      logic r1;
      logic r2;
   } share_bundle_t;

   // Five Galois right-shift steps unrolled into one combinational advance.
   function automatic logic [LFSR_W-1:0] lfsr_step5(input logic [LFSR_W-1:0] s,
                                                    input logic [LFSR_W-1:0] poly);
      logic [LFSR_W-1:0] t;
      t = s;
      for (int unsigned i = 0; i < LFSR_STEPS; i++) begin
         t = t[0] ? ((t >> 1) ^ poly) : (t >> 1);
      end
      return t;
   endfunction

endpackage

// File: rtl/mask_lfsr.sv
// Mask/randomness LFSR: reset seed, runtime reseed with zero-seed substitution,
// and an enable-gated five-step advance.
module mask_lfsr
   import masked_pkg::*;
#(
   parameter logic [LFSR_W-1:0] POLY = DEF_POLY,
   parameter logic [LFSR_W-1:0] SEED = DEF_SEED
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 load,
   input  logic [LFSR_W-1:0]    seed,
   input  logic                 advance,
   output logic [MASK_BITS-1:0] bits
);

   logic [LFSR_W-1:0] state_q;

   // An all-zero state would lock the LFSR, so a zero seed falls back to SEED.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED;
      end else if (load) begin
         state_q <= (seed == '0) ? SEED : seed;
      end else if (advance) begin
         state_q <= lfsr_step5(state_q, POLY);
      end
   end

   assign bits = state_q[MASK_BITS-1:0];

endmodule

// File: rtl/masked_xor_share_feeder.sv
// Front end of the 2-share masked XOR gate: splits a/b into Boolean shares and
// attaches fresh randomness, behind valid/ready handshakes on both sides.
module masked_xor_share_feeder
   import masked_pkg::*;
#(
   parameter logic [LFSR_W-1:0] POLY   = DEF_POLY,
   parameter logic [LFSR_W-1:0] SEED   = DEF_SEED,
   parameter int unsigned       WARMUP = DEF_WARMUP
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              a,
   input  logic              b,
   input  logic              seed_valid,
   input  logic [LFSR_W-1:0] seed,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              A0,
   output logic              A1,
   output logic              B0,
   output logic              B1,
   output logic              r0,
   output logic              r1,
   output logic              r2,
   output logic [15:0]       txn_cnt
);

   localparam int unsigned CNT_W = (WARMUP > 1) ? $clog2(WARMUP) : 1;
   localparam int unsigned TXN_W = 16;

   localparam logic [0:0] ST_WARMUP = 1'b0;
   localparam logic [0:0] ST_RUN    = 1'b1;

   logic [0:0]           state_q, state_d;
   logic [CNT_W-1:0]     warm_cnt_q, warm_cnt_d;
   logic [MASK_BITS-1:0] lfsr_bits;
   logic                 accept;
   logic                 lfsr_adv;
   share_bundle_t        bundle_d, bundle_q;
   logic                 out_valid_q;
   logic [TXN_W-1:0]     txn_cnt_q;

   // Reseed wins over input; a stalled bundle blocks new input.
   assign in_ready = (state_q == ST_RUN) && !seed_valid && (!out_valid_q || out_ready);
   assign accept   = in_valid && in_ready;
   assign lfsr_adv = accept || ((state_q == ST_WARMUP) && !seed_valid);

   mask_lfsr #(
      .POLY (POLY),
      .SEED (SEED)
   ) u_lfsr (
      .clk     (clk),
      .rst     (rst),
      .load    (seed_valid),
      .seed    (seed),
      .advance (lfsr_adv),
      .bits    (lfsr_bits)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_WARMUP;
         warm_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         warm_cnt_q <= warm_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      warm_cnt_d = warm_cnt_q;
      if (seed_valid) begin
         state_d    = ST_WARMUP;
         warm_cnt_d = '0;
      end else begin
         case (state_q)
            ST_WARMUP: begin
               warm_cnt_d = warm_cnt_q + CNT_W'(1);
               if (warm_cnt_q == CNT_W'(WARMUP - 1)) begin
                  state_d = ST_RUN;
               end
            end
            default: state_d = ST_RUN;
         endcase
      end
   end

   // Low LFSR bits: ma, mb, then r0..r2.
   always_comb begin
      bundle_d    = '0;
      bundle_d.A0 = a ^ lfsr_bits[0];
      bundle_d.A1 = lfsr_bits[0];
      bundle_d.B0 = b ^ lfsr_bits[1];
      bundle_d.B1 = lfsr_bits[1];
      bundle_d.r0 = lfsr_bits[2];
      bundle_d.r1 = lfsr_bits[3];
      bundle_d.r2 = lfsr_bits[4];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q <= 1'b0;
         bundle_q    <= '0;
         txn_cnt_q   <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         bundle_q    <= bundle_d;
         txn_cnt_q   <= txn_cnt_q + TXN_W'(1);
      end else if (out_ready) begin
         out_valid_q <= 1'b0;
      end
   end

   assign out_valid = out_valid_q;
   assign A0        = bundle_q.A0;
   assign A1        = bundle_q.A1;
   assign B0        = bundle_q.B0;
   assign B1        = bundle_q.B1;
   assign r0        = bundle_q.r0;
   assign r1        = bundle_q.r1;
   assign r2        = bundle_q.r2;
   assign txn_cnt   = txn_cnt_q;

endmodule

// File: tb/tb_masked_xor_share_feeder.sv
// Scoreboard bench for masked_xor_share_feeder: a reference model pushes the
// expected bundle on every accept, a negedge monitor pops and compares.
module tb_masked_xor_share_feeder;

   localparam logic [31:0] POLY = 32'h8020_0003;
   localparam logic [31:0] SEED = 32'h1ACE_B00C;
   localparam int          WARM = 8;

   localparam int W_NONE      = 0;
   localparam int W_RST       = 1;
   localparam int W_CNT1024   = 2;
   localparam int W_LFSR_SEED = 3;
   localparam int W_CNT_FFFF  = 4;
   localparam int W_CNT_WRAP  = 5;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        a;
   logic        b;
   logic        seed_valid;
   logic [31:0] seed;
   logic        out_valid;
   logic        out_ready;
   logic        A0, A1, B0, B1, r0, r1, r2;
   logic [15:0] txn_cnt;

   // driver-owned controls
   int  want    = 0;
   int  arm_seq = 0;
   bit  chk_en  = 1'b0;

   // monitor-owned counters
   int  n_vec     = 0;
   int  n_err     = 0;
   int  arm_seen  = 0;
   int  lo_run    = 0;
   bit  lo_active = 1'b0;

   // model-owned state
   logic [31:0] m_lfsr;
   int          m_warm;
   bit          m_run;
   bit          m_ov;
   logic [15:0] m_cnt;
   bit          acc;
   logic [6:0]  sb[$];

   masked_xor_share_feeder dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a          (a),
      .b          (b),
      .seed_valid (seed_valid),
      .seed       (seed),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .A0         (A0),
      .A1         (A1),
      .B0         (B0),
      .B1         (B1),
      .r0         (r0),
      .r1         (r1),
      .r2         (r2),
      .txn_cnt    (txn_cnt)
   );

   initial forever #5 clk = ~clk;

   function automatic logic [31:0] m_step5(input logic [31:0] s);
      logic [31:0] t;
      t = s;
      for (int k = 0; k < 5; k++) begin
         if (t[0]) t = (t >> 1) ^ POLY;
         else      t = t >> 1;
      end
      return t;
   endfunction

   function automatic bit m_ready();
      return m_run && !seed_valid && (!m_ov || out_ready);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: evaluated on the same edge the DUT samples inputs.
   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_lfsr = SEED;
         m_warm = 0;
         m_run  = 1'b0;
         m_ov   = 1'b0;
         m_cnt  = 16'd0;
         sb.delete();
      end else begin
         acc = in_valid && m_ready();
         if (seed_valid) begin
            m_lfsr = (seed == 32'd0) ? SEED : seed;
            m_warm = 0;
            m_run  = 1'b0;
         end else if (!m_run) begin
            m_lfsr = m_step5(m_lfsr);
            if (m_warm == WARM - 1) m_run = 1'b1;
            m_warm++;
         end else if (acc) begin
            sb.push_back({a ^ m_lfsr[0], m_lfsr[0], b ^ m_lfsr[1], m_lfsr[1],
                          m_lfsr[2], m_lfsr[3], m_lfsr[4]});
            m_lfsr = m_step5(m_lfsr);
            m_cnt  = m_cnt + 16'd1;
         end
         if (acc)            m_ov = 1'b1;
         else if (out_ready) m_ov = 1'b0;
      end
   end

   // Monitor: compares mid-cycle, pops the scoreboard when the bundle is taken.
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("in_ready", 32'(in_ready), 32'(m_ready()));
         check("out_valid", 32'(out_valid), 32'(m_ov));
         check("txn_cnt", 32'(txn_cnt), 32'(m_cnt));
         check("lfsr_state", dut.u_lfsr.state_q, m_lfsr);
         if (out_valid) begin
            if (sb.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL sb_underflow: got out_valid=1, expected no bundle (t=%0t)", $time);
            end else begin
               check("bundle", 32'({A0, A1, B0, B1, r0, r1, r2}), 32'(sb[0]));
               if (out_ready) sb.delete(0);
            end
         end
         case (want)
            W_RST: begin
               check("rst_out_valid", 32'(out_valid), 32'd0);
               check("rst_txn_cnt", 32'(txn_cnt), 32'd0);
               check("rst_bundle", 32'({A0, A1, B0, B1, r0, r1, r2}), 32'd0);
               check("rst_lfsr", dut.u_lfsr.state_q, 32'h1ACE_B00C);
            end
            W_CNT1024:   check("txn_cnt_1024", 32'(txn_cnt), 32'd1024);
            W_LFSR_SEED: check("zero_seed_lfsr", dut.u_lfsr.state_q, 32'h1ACE_B00C);
            W_CNT_FFFF: begin
               check("txn_cnt_ffff", 32'(txn_cnt), 32'h0000_FFFF);
               check("ffff_out_valid", 32'(out_valid), 32'd1);
            end
            W_CNT_WRAP: begin
               check("txn_cnt_wrap", 32'(txn_cnt), 32'd0);
               check("wrap_out_valid", 32'(out_valid), 32'd1);
            end
            default: ;
         endcase
         // Length of the in_ready-low window after reset/reseed.
         if (arm_seq != arm_seen) begin
            arm_seen  = arm_seq;
            lo_run    = 0;
            lo_active = 1'b1;
         end
         if (lo_active) begin
            if (!in_ready) begin
               lo_run++;
               if (lo_run > 40) begin
                  check("ready_low_cycles", 32'(lo_run), 32'(WARM));
                  lo_active = 1'b0;
               end
            end else begin
               check("ready_low_cycles", 32'(lo_run), 32'(WARM));
               lo_active = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      want = W_NONE;
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0;
      a          = 1'b0;
      b          = 1'b0;
      seed_valid = 1'b0;
      seed       = 32'd0;
      out_ready  = 1'b1;
      tick();
      chk_en  = 1'b1;
      rst     = 1'b0;
      arm_seq = arm_seq + 1;
      want    = W_RST;

      // Warm-up with in_valid held, then 1024 accepts over all (a,b) combos.
      in_valid = 1'b1;
      for (int i = 0; i < WARM + 1024; i++) begin
         a = i[0];
         b = i[1];
         tick();
      end
      in_valid = 1'b0;
      want     = W_CNT1024;
      tick();

      // Downstream stall: bundle held, no accept, LFSR frozen.
      in_valid = 1'b1; a = 1'b1; b = 1'b0;
      tick();
      out_ready = 1'b0; a = 1'b0; b = 1'b1;
      repeat (5) tick();
      out_ready = 1'b1;
      tick();
      in_valid = 1'b0;
      tick();

      // Zero seed falls back to the reset seed and replays the reset sequence.
      seed_valid = 1'b1; seed = 32'd0;
      tick();
      seed_valid = 1'b0;
      arm_seq    = arm_seq + 1;
      want       = W_LFSR_SEED;
      in_valid   = 1'b1;
      for (int i = 0; i < WARM + 16; i++) begin
         a = i[0];
         b = i[1];
         tick();
      end

      // Reseed collides with input while a bundle is pending.
      in_valid = 1'b0;
      tick();
      out_ready = 1'b0; in_valid = 1'b1; a = 1'b1; b = 1'b1;
      tick();
      seed_valid = 1'b1; seed = 32'hDEAD_BEEF; a = 1'b0;
      tick();
      seed_valid = 1'b0;
      arm_seq    = arm_seq + 1;
      repeat (2) tick();
      out_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         a = i[1];
         b = i[0];
         tick();
      end

      // Long run to txn_cnt 0xFFFF, then wrap, then reset with a pending bundle.
      in_valid = 1'b0;
      rst      = 1'b1;
      tick();
      rst     = 1'b0;
      arm_seq = arm_seq + 1;
      in_valid = 1'b1;
      for (int i = 0; i < WARM + 65535; i++) begin
         a = i[0];
         b = i[1];
         tick();
      end
      in_valid = 1'b0; out_ready = 1'b0;
      want     = W_CNT_FFFF;
      tick();
      in_valid = 1'b1; out_ready = 1'b1; a = 1'b1; b = 1'b1;
      tick();
      want = W_CNT_WRAP;
      a = 1'b0;
      tick();
      b = 1'b0;
      tick();
      in_valid = 1'b0; out_ready = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst  = 1'b0;
      want = W_RST;
      tick();
      repeat (3) tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
